regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-register file with two read ports and one write port.
- Adds a per-register scoreboard (pending bits) so the processor pipeline can stall on RAW hazards.
- Sits in decode: issue reserves the destination register, writeback writes it and clears the reservation.
- Replaces per-register tri-state output enables with muxed, registered read ports.

Parameters:
- DATA_W, 32, width of each register in bits.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NREG.

Ports:
- clk  input  1  sole clock, rising edge.
- clr  input  1  reset, synchronous, active-high; highest priority.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- re  input  1  read enable for both read ports.
- raddrA  input  ADDR_W  read port A address.
- raddrB  input  ADDR_W  read port B address.
- rdataA  output  DATA_W  registered read data, port A.
- rdataB  output  DATA_W  registered read data, port B.
- rsv_en  input  1  reserve (mark pending) request.
- rsv_addr  input  ADDR_W  register to reserve.
- pendingA  output  1  combinational: pending bit of raddrA.
- pendingB  output  1  combinational: pending bit of raddrB.
- any_pending  output  1  combinational: OR of all pending bits.

Behaviour:
- Reset: clr sampled high clears all registers, all pending bits, rdataA and rdataB to 0 at the next edge. It overrides we, re and rsv_en in the same cycle. Reset asserted mid-operation discards any in-flight write or reservation.
- Write: we=1 and waddr!=0 stores wdata at the edge. Writes to address 0 are ignored. Writes to address >= NREG are ignored.
- Read timing:
  - Latency is 1 cycle: re=1 at edge N gives rdataA/B valid after edge N, held until the next re=1 or clr.
  - re=0 holds rdataA/B at their previous values.
  - Address 0, or any address >= NREG, reads 0.
- Same-cycle write and read to the same address: governed by REGFILE_BYPASS_EN (see Optional Feature).
- Scoreboard, per register bit p[i] (p[0] constant 0):
  - set when rsv_en=1 and rsv_addr=i;
  - cleared when we=1 and waddr=i;
  - both in the same cycle for the same i: set wins, because the new producer supersedes.
  - Reserve of address 0 or >= NREG is ignored.
- Pending outputs:
  - pendingA/B = p[raddrA]/p[raddrB] from the current state. They do not reflect same-cycle rsv_en or we.
  - Out-of-range addresses give 0.
- Boundaries:
  - Reserving an already-pending register keeps it pending.
  - A write to a non-pending register is legal and leaves p unchanged.
  - raddrA=raddrB is legal; both ports return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read with re=1 whose address equals waddr, with we=1 and address !=0, captures wdata (write-first), so data written at edge N is visible after edge N.
- Undefined: read-first; the read captures the pre-write contents, and the new value is visible only on a read at edge N+1 or later.
- The scoreboard is unaffected either way.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/NREG/ADDR_W constants;
  - typedefs reg_addr_t and reg_data_t;
  - constant ZERO_REG = 0.
- Sub-module regfile_sb_scoreboard:
  - holds the NREG-bit pending vector;
  - inputs clk, clr, set enable/address, clear enable/address;
  - outputs the vector and any_pending.
- The top level holds the storage array, read muxes, output registers and bypass logic.

Test Plan:
- Reset: drive clr=1 for 1 cycle after random writes -> all reads return 0, any_pending=0, rdataA/B=0 the next cycle.
- Basic R/W: write 0xDEADBEEF to r5; next cycle re=1, raddrA=5 -> rdataA=0xDEADBEEF one cycle later. Write 0x1234 to r0 -> read r0 returns 0.
- Bypass: in the same cycle, we=1 to r7 with 0xA5A5A5A5 (old 0x11), re=1, raddrB=7 -> with REGFILE_BYPASS_EN rdataB=0xA5A5A5A5, without it 0x11.
- Scoreboard: rsv r3 -> pendingA=1 (raddrA=3) the next cycle; write r3 -> pendingA=0 the next cycle. Reserve and write r3 in the same cycle -> pendingA=1.
- Hold: re=0 for 3 cycles while r5 changes -> rdataA keeps its old value; rsv r0 -> pending stays 0.
- Mid-operation reset: clr=1 in the same cycle as we=1 to r9 and rsv r9 -> r9 reads 0 and is not pending.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // Architectural register that always reads as zero and is never reserved.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending bits: reservation at issue sets a bit, writeback clears it.
// Bit ZERO_REG is constant 0; addresses >= NREG never match any bit.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              rel_en_i,
    input  logic [ADDR_W-1:0] rel_addr_i,
    output logic [NREG-1:0]   pend_o,
    output logic              any_pending_o
);

    logic [NREG-1:1] pend_q;
    logic [NREG-1:1] pend_d;

    // Set is applied after release so a new producer supersedes the retiring one.
    always_comb begin
        pend_d = pend_q;
        for (int i = ZERO_REG + 1; i < NREG; i++) begin
            if (rel_en_i && rel_addr_i == ADDR_W'(i)) pend_d[i] = 1'b0;
            if (set_en_i && set_addr_i == ADDR_W'(i)) pend_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend_o        = {pend_q, 1'b0};
    assign any_pending_o = |pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with registered read ports and a RAW scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-first.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddrA,
    input  logic [ADDR_W-1:0] raddrB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pendingA,
    output logic              pendingB,
    output logic              any_pending
);

    function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
        return (int'(a) != ZERO_REG) && (int'(a) < NREG);
    endfunction

    // Register 0 has no storage; reads of it are forced to zero below.
    logic [DATA_W-1:0] mem_q [1:NREG-1];

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (clr)                                 mem_q[gi] <= '0;
                else if (we && waddr == ADDR_W'(gi))     mem_q[gi] <= wdata;
            end
        end
    endgenerate

    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re) begin
            rdata_a_d = valid_addr(raddrA) ? mem_q[raddrA] : '0;
            rdata_b_d = valid_addr(raddrB) ? mem_q[raddrB] : '0;
`ifdef REGFILE_BYPASS_EN
            if (we && valid_addr(waddr) && waddr == raddrA) rdata_a_d = wdata;
            if (we && valid_addr(waddr) && waddr == raddrB) rdata_b_d = wdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdataA = rdata_a_q;
    assign rdataB = rdata_b_q;

    logic [NREG-1:0] pend_vec;

    regfile_sb_scoreboard #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk           (clk),
        .clr_i         (clr),
        .set_en_i      (rsv_en),
        .set_addr_i    (rsv_addr),
        .rel_en_i      (we),
        .rel_addr_i    (waddr),
        .pend_o        (pend_vec),
        .any_pending_o (any_pending)
    );

    // Pending lookups see registered state only, never same-cycle reserve/write.
    assign pendingA = valid_addr(raddrA) && pend_vec[raddrA];
    assign pendingB = valid_addr(raddrB) && pend_vec[raddrB];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
// NREG is set below 2^ADDR_W so out-of-range addresses are exercised.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int NR = 28;
    localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr, we, re, rsv_en;
    logic [AW-1:0] waddr, raddrA, raddrB, rsv_addr;
    logic [DW-1:0] wdata, rdataA, rdataB;
    logic          pendingA, pendingB, any_pending;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW)) dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddrA(raddrA), .raddrB(raddrB), .rdataA(rdataA), .rdataB(rdataB),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pendingA(pendingA), .pendingB(pendingB),
        .any_pending(any_pending)
    );

    reg_data_t m_mem [NR];
    bit        m_p   [NR];
    reg_data_t m_ra, m_rb;
    int        checks = 0;
    int        errors = 0;

    function automatic reg_data_t m_read(int a, bit w, int wa, reg_data_t wd);
        if (a == 0 || a >= NR) return '0;
        if (BYPASS && w && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit m_pend(int a);
        if (a == 0 || a >= NR) return 1'b0;
        return m_p[a];
    endfunction

    function automatic bit m_any();
        bit r = 1'b0;
        for (int i = 0; i < NR; i++) r |= m_p[i];
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
    task automatic step(input bit c, input bit w, input int wa, input reg_data_t wd,
                        input bit r, input int ra, input int rb, input bit rs, input int rsa);
        clr = c; we = w; waddr = AW'(wa); wdata = wd;
        re = r; raddrA = AW'(ra); raddrB = AW'(rb); rsv_en = rs; rsv_addr = AW'(rsa);
        @(posedge clk);
        if (c) begin
            for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_p[i] = 1'b0; end
            m_ra = '0; m_rb = '0;
        end else begin
            if (r) begin
                m_ra = m_read(ra, w, wa, wd);
                m_rb = m_read(rb, w, wa, wd);
            end
            if (w && wa != 0 && wa < NR) begin m_mem[wa] = wd; m_p[wa] = 1'b0; end
            if (rs && rsa != 0 && rsa < NR) m_p[rsa] = 1'b1;
        end
        @(negedge clk);
        $display("txn clr=%0d we=%0d wa=%0d wd=%h re=%0d ra=%0d rb=%0d rsv=%0d/%0d",
                 c, w, wa, wd, r, ra, rb, rs, rsa);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL reset_rdataA got %h exp 0", rdataA); end
        checks++; if (rdataB !== 32'h0) begin errors++; $display("FAIL reset_rdataB got %h exp 0", rdataB); end
        checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", any_pending); end
        for (int i = 0; i < 6; i++)
            step(0, 1, $urandom_range(1, NR-1), $urandom, 1, $urandom_range(1, NR-1),
                 $urandom_range(1, NR-1), 1, $urandom_range(1, NR-1));
        checks++; if (any_pending !== 1'b1) begin errors++; $display("FAIL pre_reset_any got %b exp 1", any_pending); end
        step(1, 1, 4, 32'hFFFF_FFFF, 1, 4, 5, 1, 4);
        checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL clr_rdataA got %h exp 0", rdataA); end
        checks++; if (rdataB !== 32'h0) begin errors++; $display("FAIL clr_rdataB got %h exp 0", rdataB); end
        checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL clr_any got %b exp 0", any_pending); end
        for (int i = 1; i < NR; i += 3) begin
            step(0, 0, 0, 0, 1, i, i + 1, 0, 0);
            checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL clr_read_A r%0d got %h exp 0", i, rdataA); end
            checks++; if (rdataB !== 32'h0) begin errors++; $display("FAIL clr_read_B r%0d got %h exp 0", i + 1, rdataB); end
        end
    endtask

    task automatic test_basic_rw();
        step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 5, 0, 0);
        checks++; if (rdataA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_r5_A got %h exp deadbeef", rdataA); end
        checks++; if (rdataB !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_r5_B got %h exp deadbeef", rdataB); end
        step(0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 5, 0, 0);
        checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL rw_r0 got %h exp 0", rdataA); end
        step(0, 1, 30, 32'h5555_5555, 0, 0, 0, 0, 0);
        step(0, 1, NR-1, 32'hCAFE_0001, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30, NR-1, 0, 0);
        checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL rw_oob got %h exp 0", rdataA); end
        checks++; if (rdataB !== 32'hCAFE_0001) begin errors++; $display("FAIL rw_last got %h exp cafe0001", rdataB); end
    endtask

    task automatic test_bypass();
        reg_data_t exp_b;
        step(0, 1, 7, 32'h0000_0011, 0, 0, 0, 0, 0);
        step(0, 1, 7, 32'hA5A5_A5A5, 1, 0, 7, 0, 0);
        exp_b = BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0011;
        checks++; if (rdataB !== exp_b) begin errors++; $display("FAIL bypass_same got %h exp %h", rdataB, exp_b); end
        step(0, 0, 0, 0, 1, 7, 7, 0, 0);
        checks++; if (rdataB !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_next got %h exp a5a5a5a5", rdataB); end
    endtask

    task automatic test_scoreboard();
        step(0, 0, 0, 0, 0, 3, 3, 1, 3);
        checks++; if (pendingA !== 1'b1) begin errors++; $display("FAIL sb_rsv got %b exp 1", pendingA); end
        checks++; if (pendingB !== 1'b1) begin errors++; $display("FAIL sb_rsv_B got %b exp 1", pendingB); end
        step(0, 1, 3, 32'h3333, 0, 3, 3, 0, 0);
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL sb_wb got %b exp 0", pendingA); end
        step(0, 1, 3, 32'h3334, 0, 3, 3, 1, 3);
        checks++; if (pendingA !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", pendingA); end
        step(0, 0, 0, 0, 0, 3, 3, 1, 3);
        checks++; if (pendingA !== 1'b1) begin errors++; $display("FAIL sb_rersv got %b exp 1", pendingA); end
        rsv_en = 1'b1; rsv_addr = AW'(4); raddrA = AW'(4); we = 1'b0; re = 1'b0; clr = 1'b0;
        #1;
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL sb_no_fwd got %b exp 0", pendingA); end
        step(0, 0, 0, 0, 0, 4, 30, 1, 4);
        checks++; if (pendingA !== 1'b1) begin errors++; $display("FAIL sb_r4 got %b exp 1", pendingA); end
        step(0, 1, 3, 32'h3335, 0, 30, 3, 1, 30);
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL sb_oob got %b exp 0", pendingA); end
        checks++; if (pendingB !== 1'b0) begin errors++; $display("FAIL sb_wb_B got %b exp 0", pendingB); end
        step(0, 1, 4, 32'h4444, 0, 4, 4, 0, 0);
        checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL sb_any_clear got %b exp 0", any_pending); end
    endtask

    task automatic test_hold();
        step(0, 0, 0, 0, 1, 5, 7, 0, 0);
        checks++; if (rdataA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_init got %h exp deadbeef", rdataA); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5, $urandom, 0, 5, 5, 0, 0);
            checks++; if (rdataA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_c%0d got %h exp deadbeef", i, rdataA); end
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL hold_rsv0 got %b exp 0", pendingA); end
        checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL hold_rsv0_any got %b exp 0", any_pending); end
        step(0, 0, 0, 0, 1, 5, 5, 0, 0);
        checks++; if (rdataA !== m_ra) begin errors++; $display("FAIL hold_after got %h exp %h", rdataA, m_ra); end
    endtask

    task automatic test_mid_reset();
        step(0, 1, 9, 32'h0000_0009, 0, 0, 0, 0, 0);
        step(1, 1, 9, 32'h9999_9999, 0, 9, 9, 1, 9);
        step(0, 0, 0, 0, 1, 9, 9, 0, 0);
        checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", rdataA); end
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL midrst_pend got %b exp 0", pendingA); end
        checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL midrst_any got %b exp 0", any_pending); end
    endtask

    task automatic test_random();
        int wa, ra, rb;
        for (int n = 0; n < 400; n++) begin
            wa = $urandom_range(0, 31);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 31);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 2) != 0, ra, rb, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31));
            checks++; if (rdataA !== m_ra) begin errors++; $display("FAIL rnd%0d_rdataA got %h exp %h", n, rdataA, m_ra); end
            checks++; if (rdataB !== m_rb) begin errors++; $display("FAIL rnd%0d_rdataB got %h exp %h", n, rdataB, m_rb); end
            checks++; if (pendingA !== m_pend(ra)) begin errors++; $display("FAIL rnd%0d_pendA got %b exp %b", n, pendingA, m_pend(ra)); end
            checks++; if (pendingB !== m_pend(rb)) begin errors++; $display("FAIL rnd%0d_pendB got %b exp %b", n, pendingB, m_pend(rb)); end
            checks++; if (any_pending !== m_any()) begin errors++; $display("FAIL rnd%0d_any got %b exp %b", n, any_pending, m_any()); end
        end
    endtask

    initial begin
        clr = 1'b1; we = 1'b0; re = 1'b0; rsv_en = 1'b0;
        waddr = '0; wdata = '0; raddrA = '0; raddrB = '0; rsv_addr = '0;
        test_reset();
        test_basic_rw();
        test_bypass();
        test_scoreboard();
        test_hold();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
